// File: rtl/word_stream_pkg.sv
// word_stream_pkg: shared FSM state type, LFSR constants and step function
package word_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] LFSR_SEED_FIX = 32'h1;
  localparam logic [31:0] EXT_HI = 32'hFFFFFFFF;
  localparam logic [31:0] EXT_LO = 32'h0;
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction
endpackage

// File: rtl/stream_lfsr.sv
// stream_lfsr: 32-bit Galois LFSR register with load and advance enables
// Ports: clk, rst (async active-low, clears q); load/load_val overwrite q;
// adv steps q once; q is the current register value.
module stream_lfsr
  import word_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] load_val,
  output logic [31:0] q
);
  logic [31:0] q_d, q_q;
  always_comb q_d = load ? load_val : adv ? lfsr_step(q_q) : q_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/word_stream_gen.sv
// word_stream_gen: burst generator of LFSR words over a valid/ready stream
// Ports: clk, rst (async active-low); start/seed/count launch a burst from IDLE;
// out_data/out_valid/out_ready form the stream; busy is high in RUN; done pulses
// once at burst end. Define WORD_STREAM_GEN_EXTREMES_EN to lead every burst with
// 32'hFFFFFFFF then 32'h0 (both counted in count) before the seeded LFSR words.
module word_stream_gen
  import word_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic load, adv, xfer, last;
  logic [31:0] load_val, fseed;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
  // ext_q: 0 = showing EXT_HI, 1 = showing EXT_LO, 2 = LFSR phase
  logic [1:0] ext_q, ext_d;
  logic [31:0] seed_q, seed_d;
`endif
  assign xfer = out_valid_q & out_ready;
  // cnt_q holds words still to transfer, so the final transfer sees 1
  assign last = cnt_q == CNT_W'(1);
  assign fseed = (seed == '0) ? LFSR_SEED_FIX : seed;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    load = 1'b0;
    adv = 1'b0;
    load_val = fseed;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
    ext_d = ext_q;
    seed_d = seed_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = (count != '0) ? RUN : DONE;
        cnt_d = count;
        load = count != '0;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
        load_val = EXT_HI;
        seed_d = fseed;
        ext_d = 2'd0;
`endif
      end
      RUN: if (xfer) begin
        cnt_d = cnt_q - CNT_W'(1);
        state_d = last ? DONE : RUN;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
        load = !last && !ext_q[1];
        adv = !last && ext_q[1];
        load_val = ext_q[0] ? seed_q : EXT_LO;
        ext_d = ext_q[1] ? ext_q : ext_q + 2'd1;
`else
        adv = !last;
`endif
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = state_d == RUN;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
      ext_q <= 2'd0;
      seed_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef WORD_STREAM_GEN_EXTREMES_EN
      ext_q <= ext_d;
      seed_q <= seed_d;
`endif
    end
  stream_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .adv      (adv),
    .load_val (load_val),
    .q        (out_data)
  );
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: doc/word_stream_gen.md
WORD_STREAM_GEN -- requirements
Module: word_stream_gen

Interface
REQ-001 SHALL have parameter: DATA_W, 32, output word width (fixed at 32 for the LFSR).
REQ-002 SHALL have parameter: CNT_W, 16, width of the word-count input.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  begin a burst; sampled only in IDLE.
REQ-006 SHALL have port: seed  input  32  LFSR start value, captured with start.
REQ-007 SHALL have port: count  input  CNT_W  number of words in the burst, captured with start.
REQ-008 SHALL have port: out_data  output  32  current stream word (the `in` of a downstream max/min tracker).
REQ-009 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the word; transfer = out_valid & out_ready.
REQ-011 SHALL have port: busy  output  1  high in RUN.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at burst end.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE: start=1 with count!=0 SHALL capture seed/count and enter RUN; out_valid high the next cycle.
REQ-015 IDLE: start=1 with count=0 SHALL enter DONE directly; no word emitted.
REQ-016 A zero seed SHALL be replaced by 32'h00000001.
REQ-017 The first LFSR word SHALL be the (fixed-up) seed.
REQ-018 Each later word SHALL be the Galois step of the previous word: {1'b0, x[31:1]} XOR (x[0] ? 32'h80200003 : 0).
REQ-019 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 The next word SHALL appear the cycle after a transfer; zero-bubble streaming SHALL be supported while out_ready stays high.
REQ-021 After the count-th transfer: out_valid SHALL drop the next cycle and the FSM SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle: done=1, busy=0, out_valid=0, then IDLE.
REQ-023 start in RUN or DONE SHALL be ignored.
REQ-024 start in IDLE SHALL be honoured on the cycle after done.
REQ-025 The transfer counter SHALL be CNT_W bits; count=2^CNT_W-1 SHALL emit exactly that many words with no wrap.

Reset
REQ-026 rst=0 SHALL force, immediately and asynchronously: IDLE, out_data=0, out_valid=0, busy=0, done=0, counter=0.
REQ-027 Reset mid-burst SHALL abandon the burst with no done pulse.
REQ-028 After reset release, the first burst SHALL need a fresh start.

Configuration
REQ-029 Macro WORD_STREAM_GEN_EXTREMES_EN SHALL control extreme-word injection.
REQ-030 With WORD_STREAM_GEN_EXTREMES_EN defined: word 1 = 32'hFFFFFFFF, word 2 = 32'h00000000, then seed and LFSR words; both injected words count toward count.
REQ-031 With count=1 and the macro defined, only 32'hFFFFFFFF SHALL be emitted.
REQ-032 Without the macro: pure LFSR stream per REQ-017/018.

Structure
REQ-033 Package word_stream_pkg SHALL hold: the FSM state enum, LFSR_MASK=32'h80200003, LFSR_SEED_FIX=32'h1, EXT_HI=32'hFFFFFFFF, EXT_LO=32'h0.
REQ-034 Sub-module stream_lfsr SHALL hold the 32-bit register with load/advance enables; the FSM, counter and handshake SHALL stay in word_stream_gen.

Verification
REQ-035 Macro off, seed=1, count=3, out_ready=1 -> out_data 0x00000001, 0x80200003, 0xC0300002 on consecutive cycles; done pulses once; busy low after.
REQ-036 Same burst, out_ready low 4 cycles on word 2 -> 0x80200003 held unchanged, out_valid stays 1; sequence unchanged.
REQ-037 seed=0, count=1 -> single word 0x00000001; count=0 -> done pulse the cycle after start, out_valid never asserted.
REQ-038 rst asserted mid-burst, after 2 of 5 words -> all outputs 0 at once, no done; a new start emits from the new seed.
REQ-039 Macro on, seed=1, count=4 -> 0xFFFFFFFF, 0x00000000, 0x00000001, 0x80200003; downstream max/min tracker reads max=0xFFFFFFFF, min=0x00000000 (unsigned).
REQ-040 start pulsed during RUN and during DONE -> ignored, word count unchanged; start the cycle after done -> new burst accepted.
